// File: rtl/ring_digit_scanner_pkg.sv
// Shared types and helpers for the ring-counter digit scanner: FSM states,
// digit count, one-hot rotation and one-hot to index decode.
package ring_digit_scanner_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int NDIG = 4;

   function automatic logic [3:0] rotl4(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ring_digit_buffer.sv
// Shadow/active double buffer: loads land in shadow, and the shadow is promoted
// to active only at a frame boundary so a scan never mixes two words.
module ring_digit_buffer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         load,
   input  logic         swap,
   output logic [W-1:0] frame_word
);

   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] active_q, active_d;
   logic         pending_q, pending_d;
   logic         do_swap;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      do_swap   = swap && pending_q;
      shadow_d  = load ? din : shadow_q;
      active_d  = do_swap ? shadow_q : active_q;
      pending_d = pending_q;
      if (do_swap) pending_d = 1'b0;
      // A load on the swap edge becomes the next frame's pending word.
      if (load) pending_d = 1'b1;
      frame_word = do_swap ? shadow_q : active_q;
   end

endmodule

// File: rtl/ring_digit_scanner.sv
// Digit scanner driven by a one-hot ring counter: checks the rotation,
// strobes one digit per cycle, and blanks/counts on sequence faults.
module ring_digit_scanner
   import ring_digit_scanner_pkg::*;
#(
   parameter int DW   = 4,
   parameter int HOLD = 8,
   parameter int ERRW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        phase,
   input  logic [4*DW-1:0]   din,
   input  logic              load,
   output logic [3:0]        an,
   output logic [DW-1:0]     seg,
   output logic              phase_err,
   output logic              fault_active,
   output logic [ERRW-1:0]   err_count
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   state_t            state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [3:0]        prev_q, prev_d;
   logic [3:0]        an_q, an_d;
   logic [DW-1:0]     seg_q, seg_d;
   logic              perr_q, perr_d;
   logic              fault_q, fault_d;
   logic [ERRW-1:0]   err_q, err_d;
   logic              accept;
   logic              bad;
   logic              boundary;
   logic [4*DW-1:0]   frame_word;

   ring_digit_buffer #(.W(4*DW)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .load       (load),
      .swap       (boundary),
      .frame_word (frame_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SYNC;
         hold_q  <= '0;
         prev_q  <= '0;
         an_q    <= '0;
         seg_q   <= '0;
         perr_q  <= 1'b0;
         fault_q <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         prev_q  <= prev_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         perr_q  <= perr_d;
         fault_q <= fault_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      prev_d  = prev_q;
      accept  = 1'b0;
      bad     = 1'b0;
      case (state_q)
         SYNC: begin
            // Illegal phases are simply ignored while waiting for lock.
            if (phase == 4'b0001) begin
               state_d = RUN;
               accept  = 1'b1;
            end
         end
         RUN: begin
            if (phase == rotl4(prev_q)) begin
               accept = 1'b1;
            end else begin
               state_d = FAULT;
               hold_d  = HW'(HOLD - 1);
               bad     = 1'b1;
            end
         end
         FAULT: begin
            if (hold_q == '0) state_d = SYNC;
            else              hold_d  = hold_q - HW'(1);
         end
         default: state_d = SYNC;
      endcase
      if (accept) prev_d = phase;
      boundary = accept && (phase == 4'b0001);
   end

   always_comb begin
      an_d    = accept ? phase : 4'b0000;
      seg_d   = accept ? frame_word[onehot_idx(phase)*DW +: DW] : '0;
      perr_d  = bad;
      fault_d = (state_d == FAULT);
      err_d   = err_q;
      if (bad && (err_q != '1)) err_d = err_q + ERRW'(1);
   end

   assign an           = an_q;
   assign seg          = seg_q;
   assign phase_err    = perr_q;
   assign fault_active = fault_q;
   assign err_count    = err_q;

endmodule

// File: doc/ring_digit_scanner.md
Name: ring_digit_scanner

Overview:
- Downstream consumer of the 4-bit one-hot ring counter output.
- Uses the rotating phase as the digit-select strobe for a 4-digit time-multiplexed display/bus.
- Checks that the phase sequence is legal (one-hot, rotating left). Blanks the outputs and counts faults when it is not.
- Double-buffers incoming 16-bit data so a frame never tears mid-scan.

Parameters:
- DW, 4, bits per digit; data word is 4*DW.
- HOLD, 8, cycles spent in FAULT before resynchronising (>=1).
- ERRW, 8, width of saturating fault counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- phase  input  4  one-hot phase from ring counter. Counter updates on negedge, so phase is stable at posedge.
- din  input  4*DW  new display word; digit k = din[k*DW +: DW].
- load  input  1  capture din into shadow buffer this cycle.
- an  output  4  registered digit enable (one-hot or 0).
- seg  output  DW  registered data for the enabled digit (0 when an==0).
- phase_err  output  1  one-cycle pulse on fault detection.
- fault_active  output  1  high while in FAULT.
- err_count  output  ERRW  saturating count of faults.

Behaviour:
- Reset (sync, rst high at posedge): state=SYNC, an=0, seg=0, phase_err=0, fault_active=0, err_count=0, active=0, shadow=0, pending=0, prev=0. Reset mid-frame or mid-FAULT aborts immediately and is identical to power-up reset.
- All outputs are registered. Latency is 1 cycle from phase sampled to an/seg.
- SYNC: an=0, seg=0.
  - Sampled phase==4'b0001 -> RUN; same edge drives an=0001, seg=digit0, prev=0001.
  - Any other value, including illegal ones, is ignored; no fault is flagged.
- RUN: expected = rotate-left(prev), i.e. 0001->0010->0100->1000->0001.
  - phase==expected: an<=phase, seg<=digit[index(phase)], prev<=phase.
  - Otherwise (zero, multi-hot, skip, reverse): -> FAULT; an<=0, seg<=0, phase_err<=1 for one cycle, err_count<=err_count+1 saturating at all-ones, hold counter<=HOLD-1.
- FAULT: an=0, seg=0, fault_active=1. The hold counter decrements each cycle; phase is ignored. At 0 -> SYNC on the next edge (exactly HOLD cycles in FAULT).
- Buffering:
  - load=1: shadow<=din, pending<=1. A load while already pending overwrites shadow; last load wins.
  - Frame boundary = accepted phase 0001 in SYNC->RUN or RUN. If pending: active<=shadow, pending<=0, and seg for digit 0 on that edge comes from the shadow value prior to the edge.
  - Load on a boundary edge: the swap uses the old shadow; the new din lands in shadow with pending=1 for the next frame. If pending was 0, no swap occurs and the new data waits for the next frame.
  - Loads in SYNC/FAULT are accepted into shadow; the swap waits for the next boundary.
- err_count is never cleared except by rst.

Decomposition:
- Shared package:
  - state enum {SYNC, RUN, FAULT}.
  - NDIG=4 constant.
  - rotl4 function.
  - onehot-to-index function (2-bit).
- One natural sub-module: ring_digit_buffer (shadow/active/pending registers + swap logic). FSM and checker stay in top.

Test Plan:
- Reset, then load din=16'h4321. Drive phase 0001,0010,0100,1000 repeatedly -> after 1-cycle latency: an follows phase, seg=1,2,3,4 cyclically; phase_err never set.
- Mid-frame (phase=0100), load din=16'hABCD -> seg remains 3,4 for the current frame; the next 0001 gives seg=D, then C,B,A.
- In RUN, inject phase=0110 after 0010 -> next edge: an=0, phase_err=1 for exactly one cycle, err_count=1, fault_active high 8 cycles. Then SYNC and relock on the next 0001.
- In SYNC, drive 0000, 1000, 0100 -> no fault, an=0; on 0001 -> an=0001.
- With ERRW=2, force 5 faults -> err_count reaches 3 and holds.
- Assert rst during FAULT with pending=1 -> next edge: all outputs 0, pending cleared; the first frame after relock shows seg=0.
